// File: rtl/isqrt_arb_pkg.sv
// Shared widths and helpers for the isqrt arbiter: argument/result widths and
// the tag width needed to name one requester.
package isqrt_arb_pkg;

  localparam int ARG_W = 32;
  localparam int RES_W = 16;

  // Tag must be at least one bit wide even for a single requester.
  function automatic int tag_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/isqrt_arb_tag_fifo.sv
// In-flight tag FIFO: records which requester owns each outstanding isqrt
// operation so in-order results can be routed back to it.
module isqrt_arb_tag_fifo
  import isqrt_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // A push at full is accepted only when a pop frees the slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/isqrt_arbiter.sv
// Round-robin arbiter sharing one pipelined isqrt unit among N_REQ requesters;
// results return in order and are steered to their owner via a tag FIFO.
module isqrt_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*ARG_W-1:0] req_x,
  output logic [N_REQ-1:0]       req_rdy,
  output logic [N_REQ-1:0]       rsp_vld,
  output logic [RES_W-1:0]       rsp_y,
  output logic                   isqrt_x_vld,
  output logic [ARG_W-1:0]       isqrt_x,
  input  logic                   isqrt_y_vld,
  input  logic [RES_W-1:0]       isqrt_y,
  output logic                   busy,
  output logic                   err
);

  localparam int TW = tag_w(N_REQ);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic [ARG_W-1:0] x_arr [N_REQ];
  logic [TW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [TW-1:0]    gnt_idx, cand_idx, pop_tag;
  logic             gnt_any, can_grant, pop;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [N_REQ-1:0] rsp_vld_reg;
  logic [RES_W-1:0] rsp_y_reg;
  logic             err_reg;
  int               cand;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign x_arr[gi] = req_x[gi*ARG_W +: ARG_W];
  end

  assign pop       = isqrt_y_vld & ~fifo_empty;
  assign can_grant = ~rst & (~fifo_full | pop);

  // First asserted requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(rr_ptr_reg) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = TW'(cand);
      if (!gnt_any && req_vld[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_comb begin
    req_rdy     = (gnt_any && can_grant) ? (N_REQ'(1) << gnt_idx) : '0;
    isqrt_x_vld = |(req_vld & req_rdy);
    isqrt_x     = x_arr[gnt_idx];
    rr_ptr_next = rr_ptr_reg;
    if (isqrt_x_vld)
      rr_ptr_next = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  isqrt_arb_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (isqrt_x_vld),
    .push_data (gnt_idx),
    .pop       (pop),
    .pop_data  (pop_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg  <= '0;
      rsp_vld_reg <= '0;
      rsp_y_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      rr_ptr_reg  <= rr_ptr_next;
      rsp_vld_reg <= pop ? (N_REQ'(1) << pop_tag) : '0;
      if (pop) rsp_y_reg <= isqrt_y;
      // A result with nobody waiting for it is dropped and flagged until reset.
      if (isqrt_y_vld && fifo_empty) err_reg <= 1'b1;
    end
  end

  assign rsp_vld = rsp_vld_reg;
  assign rsp_y   = rsp_y_reg;
  assign err     = err_reg;
  assign busy    = (fifo_count != '0);

endmodule
